truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 input codes and checks its truth-table ID.
// Define MISMATCH_ABORT_EN to stop the sweep at the first mismatching sample.
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] table_q, table_d;
    logic [2:0] ff_q, ff_d;
    logic       mis_q, mis_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] dut_in_q, dut_in_d;

    logic [2:0] bit_pos;
    logic       sample_miss;
    logic       sweep_end;

    // Index 0 (input 000) lands in the MSB of the signature.
    assign bit_pos     = ~idx_q;
    assign sample_miss = (dut_out != exp_q[bit_pos]);

`ifdef MISMATCH_ABORT_EN
    assign sweep_end = (idx_q == 3'd7) || sample_miss;
`else
    assign sweep_end = (idx_q == 3'd7);
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        table_d  = table_q;
        ff_d     = ff_q;
        mis_d    = mis_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dut_in_d = dut_in_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    table_d  = 8'h00;
                    pass_d   = 1'b0;
                    ff_d     = 3'd0;
                    mis_d    = 1'b0;
                    idx_d    = 3'd0;
                    dut_in_d = 3'd0;
                    cnt_d    = 8'd0;
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                table_d[bit_pos] = dut_out;
                if (sample_miss && !mis_q) begin
                    ff_d  = idx_q;
                    mis_d = 1'b1;
                end
                if (sweep_end) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + 3'd1;
                    dut_in_d = idx_q + 3'd1;
                    cnt_d    = 8'd0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                pass_d   = (table_q == exp_q);
                busy_d   = 1'b0;
                dut_in_d = 3'd0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            cnt_q    <= 8'd0;
            exp_q    <= 8'h00;
            table_q  <= 8'h00;
            ff_q     <= 3'd0;
            mis_q    <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dut_in_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            table_q  <= table_d;
            ff_q     <= ff_d;
            mis_q    <= mis_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dut_in_q <= dut_in_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign table_out  = table_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper against a signature-level model.
// Honours MISMATCH_ABORT_EN when it is defined for the whole build.
module tb_truth_table_sweeper;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] expected;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] table_out;
    logic [2:0] first_fail;

    logic       start1;
    logic [2:0] dut_in1;
    logic       busy1;
    logic       done1;
    logic       pass1;
    logic [7:0] table1;
    logic [2:0] ff1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .expected  (expected),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .table_out (table_out),
        .first_fail(first_fail)
    );

    truth_table_sweeper #(.SETTLE(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .expected  (8'hFF),
        .dut_in    (dut_in1),
        .dut_out   (1'b1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .table_out (table1),
        .first_fail(ff1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_diff(input logic [7:0] tt,
                                      input logic [7:0] ex);
        for (int i = 0; i < 8; i++)
            if (tt[7-i] != ex[7-i]) return i;
        return 0;
    endfunction

    // One sweep from the current negedge; returns at the negedge where done
    // is seen, so an immediate second call starts back-to-back.
    task automatic sweep(input logic [7:0] tt, input logic [7:0] ex,
                         input bit disturb, input int rst_at);
        int L, last, ff, n, bad, idx_m, dn;
        bit seen, mis, abort;
        logic [7:0] tbl;
        mis = (tt != ex);
        ff = first_diff(tt, ex);
`ifdef MISMATCH_ABORT_EN
        abort = mis;
`else
        abort = 1'b0;
`endif
        last = abort ? ff : 7;
        L = (last + 1) * (S + 1) + 1;
        tbl = abort ? (tt & (8'hFF << (7 - ff))) : tt;

        expected = ex;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("acc_table", table_out, 0);
        chk("acc_pass", pass, 0);
        chk("acc_ff", first_fail, 0);

        bad = 0;
        seen = 0;
        for (n = 0; n <= L + 4; n++) begin
            if (n > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (rst_at > 0 && n == rst_at) begin
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_dut_in", dut_in, 0);
                chk("rst_table", table_out, 0);
                chk("rst_done", done, 0);
                dn = 0;
                repeat (L) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (done) dn++;
                end
                chk("rst_no_done", dn, 0);
                return;
            end
            idx_m = (n / (S + 1) > last) ? last : n / (S + 1);
            if (n >= L) idx_m = 0;
            if (dut_in != 3'(idx_m) || busy != (n < L)) bad++;
            if (done) begin
                seen = 1;
                break;
            end
            // Outside the sample cycle the gate output is garbage.
            if ((n + 1) % (S + 1) == 0) dut_out = tt[7-idx_m];
            else dut_out = 1'($urandom);
            start = disturb && (n == 3 || n == 20) && (n + 2 < L);
            if (disturb && n == 10) expected = 8'($urandom);
            rst = (rst_at > 0 && n == rst_at - 1);
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", n, L);
        chk("seq", bad, 0);
        chk("table", table_out, tbl);
        chk("pass", pass, !mis);
        chk("first_fail", first_fail, mis ? ff : 0);
    endtask

    task automatic idle_gap(input int g);
        for (int i = 0; i < g; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) chk("done_pulse", done, 0);
        end
    endtask

    initial begin
        logic [7:0] tt, ex;
        int n;
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        expected = 8'h00;
        dut_out = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_table", table_out, 0);
        chk("reset_ff", first_fail, 0);
        chk("reset_dut_in", dut_in, 0);
        rst = 1'b0;
        idle_gap(2);

        sweep(8'h50, 8'h50, 0, 0);
        idle_gap(2);
        sweep(8'h00, 8'h50, 0, 0);
        idle_gap(1);
        sweep(8'h50, 8'h50, 1, 0);
        idle_gap(2);
        sweep(8'h50, 8'h50, 0, 17);
        sweep(8'h50, 8'h50, 0, 0);
        sweep(8'hA3, 8'hA3, 0, 0);
        idle_gap(1);

        for (int k = 0; k < 12; k++) begin
            tt = 8'($urandom);
            case ($urandom_range(0, 2))
                0: ex = tt;
                1: ex = tt ^ (8'h01 << $urandom_range(0, 7));
                default: ex = 8'($urandom);
            endcase
            sweep(tt, ex, 1'($urandom), 0);
            idle_gap($urandom_range(0, 2));
        end

        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("s1_latency", n, 17);
        chk("s1_table", table1, 8'hFF);
        chk("s1_pass", pass1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
